index_mask_builder: RTL and testbench

- Inverse of the priority-encoder path: accepts a stream of slot indices, decodes each one to one-hot, and ORs them into a W-bit mask frame.
- Emits the completed mask downstream over a valid/ready handshake; the downstream priority encoder consumes it.
- Used to rebuild candidate/occupancy vectors from index lists in the match pipeline.
- Two-state FSM (ACCUM, EMIT) with registered outputs.

---
 rtl/index_mask_builder_if.sv | 29 ++
 rtl/index_mask_builder.sv | 103 ++++++++++
 tb/tb_index_mask_builder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/index_mask_builder_if.sv
// Index-in / mask-out channels of index_mask_builder.
// The slave modport is the block's view; the master modport is the environment's view.
interface index_mask_builder_if #(
    parameter int unsigned W = 16
);
    localparam int unsigned IW = $clog2(W);

    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_index;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_mask;
    logic [IW:0]   out_count;
    logic          out_full;
    logic          out_dup;
    logic          out_err;

    modport master (
        output in_valid, in_index, in_last, out_ready,
        input  in_ready, out_valid, out_mask, out_count, out_full, out_dup, out_err
    );

    modport slave (
        input  in_valid, in_index, in_last, out_ready,
        output in_ready, out_valid, out_mask, out_count, out_full, out_dup, out_err
    );
endinterface

// File: rtl/index_mask_builder.sv
// Rebuilds a W-bit occupancy mask from a stream of slot indices and hands the
// completed frame downstream over valid/ready, with popcount and frame flags.
module index_mask_builder #(
    parameter int unsigned W = 16
) (
    input logic clk,
    input logic rst_n,
    index_mask_builder_if.slave bus
);
    localparam int unsigned IW = $clog2(W);

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  mask_q, mask_d;
    logic [IW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          dup_q, dup_d;
    logic          err_q, err_d;
    logic          rdy_q, vld_q;
    logic [W-1:0]  onehot;
    logic          idx_ok;

    // Out-of-range indices shift out entirely, so onehot is zero for them.
    assign onehot = W'(1) << bus.in_index;
    assign idx_ok = 32'(bus.in_index) < W;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        count_d = count_q;
        full_d  = full_q;
        dup_d   = dup_q;
        err_d   = err_q;
        case (state_q)
            ACCUM: begin
                if (bus.in_valid) begin
                    if (!idx_ok) begin
                        err_d = 1'b1;
                    end else if ((mask_q & onehot) != '0) begin
                        dup_d = 1'b1;
                    end else begin
                        mask_d  = mask_q | onehot;
                        count_d = count_q + (IW+1)'(1);
                    end
                    if (mask_d == '1) begin
                        full_d  = 1'b1;
                        state_d = EMIT;
                    end
                    if (bus.in_last) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    mask_d  = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                    dup_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Handshake flags are flopped copies of the next state, so neither has a
    // combinational path from in_valid or out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            mask_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            dup_q   <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            full_q  <= full_d;
            dup_q   <= dup_d;
            err_q   <= err_d;
            rdy_q   <= (state_d == ACCUM);
            vld_q   <= (state_d == EMIT);
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = vld_q;
    assign bus.out_mask  = mask_q;
    assign bus.out_count = count_q;
    assign bus.out_full  = full_q;
    assign bus.out_dup   = dup_q;
    assign bus.out_err   = err_q;
endmodule

// File: tb/tb_index_mask_builder.sv
// Bench for index_mask_builder: W=16 and W=12 instances share one stimulus
// driver; a set-based frame model predicts every emitted mask.
module tb_index_mask_builder;
    logic       clk;
    logic       rst_n;
    logic       sel12;
    logic       in_valid;
    logic [3:0] in_index;
    logic       in_last;
    logic       out_ready;

    int vectors;
    int miscompares;

    index_mask_builder_if #(.W(16)) if16 ();
    index_mask_builder_if #(.W(12)) if12 ();

    assign if16.in_valid  = in_valid & ~sel12;
    assign if16.in_index  = in_index;
    assign if16.in_last   = in_last;
    assign if16.out_ready = out_ready;
    assign if12.in_valid  = in_valid & sel12;
    assign if12.in_index  = in_index;
    assign if12.in_last   = in_last;
    assign if12.out_ready = out_ready;

    index_mask_builder #(.W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    index_mask_builder #(.W(12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(if12.slave));

    logic        obs_ready, obs_valid, obs_full, obs_dup, obs_err;
    logic [15:0] obs_mask;
    logic [4:0]  obs_count;

    assign obs_ready = sel12 ? if12.in_ready  : if16.in_ready;
    assign obs_valid = sel12 ? if12.out_valid : if16.out_valid;
    assign obs_mask  = sel12 ? 16'(if12.out_mask) : if16.out_mask;
    assign obs_count = sel12 ? if12.out_count : if16.out_count;
    assign obs_full  = sel12 ? if12.out_full  : if16.out_full;
    assign obs_dup   = sel12 ? if12.out_dup   : if16.out_dup;
    assign obs_err   = sel12 ? if12.out_err   : if16.out_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame model: the set of slots hit so far plus the frame flags.
    int cur_w;
    bit seen [16];
    int m_distinct;
    bit m_dup, m_err;

    task automatic model_clear();
        for (int i = 0; i < 16; i++) seen[i] = 1'b0;
        m_distinct = 0;
        m_dup = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_push(input int idx, input bit last, output bit closes);
        if (idx >= cur_w) m_err = 1'b1;
        else if (seen[idx]) m_dup = 1'b1;
        else begin
            seen[idx] = 1'b1;
            m_distinct++;
        end
        closes = last || (m_distinct == cur_w);
    endtask

    function automatic logic [15:0] model_mask();
        int m = 0;
        for (int i = 0; i < cur_w; i++) if (seen[i]) m += 2 ** i;
        return 16'(m);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Offer one beat at a negedge and return at the negedge after it is taken.
    task automatic beat(input int idx, input bit last);
        int n = 0;
        in_index = 4'(idx);
        in_last  = last;
        in_valid = 1'b1;
        while (obs_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            vectors++;
            miscompares++;
            $error("FAIL beat_wait: in_ready stayed low for %0d cycles", n);
        end
        @(negedge clk);
    endtask

    task automatic check_emit(input string tag);
        check({tag, "_valid"}, 32'(obs_valid), 1);
        check({tag, "_ready"}, 32'(obs_ready), 0);
        check({tag, "_mask"},  32'(obs_mask),  32'(model_mask()));
        check({tag, "_count"}, 32'(obs_count), 32'(m_distinct));
        check({tag, "_full"},  32'(obs_full),  32'(m_distinct == cur_w));
        check({tag, "_dup"},   32'(obs_dup),   32'(m_dup));
        check({tag, "_err"},   32'(obs_err),   32'(m_err));
    endtask

    task automatic frame(input string tag, input int idxs[$], input bit last_end,
                         input int hold, input bit gaps);
        bit closed = 1'b0;
        bit lst;
        model_clear();
        out_ready = (hold == 0);
        for (int i = 0; i < idxs.size() && !closed; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            lst = last_end && (i == idxs.size() - 1);
            beat(idxs[i], lst);
            model_push(idxs[i], lst, closed);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_emit(tag);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_index = 4'($urandom_range(0, 15));
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(obs_valid), 1);
            check({tag, "_hold_ready"}, 32'(obs_ready), 0);
            check({tag, "_hold_mask"},  32'(obs_mask),  32'(model_mask()));
            check({tag, "_hold_count"}, 32'(obs_count), 32'(m_distinct));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_post_valid"}, 32'(obs_valid), 0);
        check({tag, "_post_ready"}, 32'(obs_ready), 1);
        check({tag, "_post_mask"},  32'(obs_mask),  0);
        check({tag, "_post_count"}, 32'(obs_count), 0);
    endtask

    initial begin
        int q[$];
        vectors = 0;
        miscompares = 0;
        sel12 = 1'b0;
        cur_w = 16;
        in_valid = 1'b0;
        in_index = '0;
        in_last = 1'b0;
        out_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_valid", 32'(obs_valid), 0);
        check("rst_mask",  32'(obs_mask),  0);
        check("rst_count", 32'(obs_count), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(obs_ready), 1);

        q = '{3, 7, 15};
        frame("basic", q, 1'b1, 0, 1'b0);
        q = '{5, 5, 2};
        frame("dup", q, 1'b1, 0, 1'b0);
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(i);
        frame("full_nolast", q, 1'b0, 0, 1'b0);
        frame("full_last", q, 1'b1, 0, 1'b0);
        q = '{1, 2};
        frame("backpressure", q, 1'b1, 5, 1'b0);
        q = '{6};
        frame("after_bp", q, 1'b1, 0, 1'b0);

        // Reset in the middle of a frame discards it.
        model_clear();
        beat(1, 1'b0);
        beat(2, 1'b0);
        in_valid = 1'b0;
        check("mid_mask", 32'(obs_mask), 32'h0006);
        rst_n = 1'b0;
        #1;
        check("mid_rst_mask",  32'(obs_mask),  0);
        check("mid_rst_count", 32'(obs_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q = '{9};
        frame("after_rst", q, 1'b1, 0, 1'b0);

        // Reset while a frame is waiting downstream drops out_valid at once.
        model_clear();
        out_ready = 1'b0;
        beat(4, 1'b1);
        in_valid = 1'b0;
        in_last = 1'b0;
        check("emit_pre_valid", 32'(obs_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("emit_rst_valid", 32'(obs_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("emit_rst_ready", 32'(obs_ready), 1);
        check("emit_rst_mask",  32'(obs_mask),  0);

        sel12 = 1'b1;
        cur_w = 12;
        q = '{4, 13};
        frame("w12_err", q, 1'b1, 0, 1'b0);
        q = '{13, 15};
        frame("w12_allbad", q, 1'b1, 0, 1'b0);
        q.delete();
        for (int i = 0; i < 12; i++) q.push_back(11 - i);
        frame("w12_full", q, 1'b0, 1, 1'b0);

        for (int r = 0; r < 40; r++) begin
            sel12 = ($urandom_range(0, 1) == 1);
            cur_w = sel12 ? 12 : 16;
            q.delete();
            if (r % 8 == 0) begin
                for (int i = 0; i < cur_w; i++) q.push_back(i);
                q.shuffle();
                frame("rand_perm", q, ($urandom_range(0, 1) == 1), $urandom_range(0, 3), 1'b1);
            end else begin
                for (int i = 0; i < int'($urandom_range(1, 12)); i++)
                    q.push_back(int'($urandom_range(0, 15)));
                frame("rand", q, 1'b1, $urandom_range(0, 3), 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
